frame_derandomizer: RTL and testbench

//  Receive-side de-randomizer for a bit-serial framed stream. Uses the same 15-bit additive LFSR
//  as the transmit randomizer (keystream bit si = r[0]^r[1]; advance r <= {si, r[14:1]}).

---
 rtl/randomizer_pkg.sv | 18 +
 rtl/randomizer_lfsr.sv | 33 +++
 rtl/frame_derandomizer.sv | 115 +++++++++++
 tb/tb_frame_derandomizer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/randomizer_pkg.sv
// Shared definitions for the framed-stream randomizer and de-randomizer:
// LFSR width, reset seed, FSM encoding and the LFSR step function.
package randomizer_pkg;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'b100101010000000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Additive LFSR step: the keystream bit is shifted in at the top
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    return {r[0] ^ r[1], r[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/randomizer_lfsr.sv
// 15-bit additive LFSR with restart-from-seed and per-bit advance.
// The keystream bit always comes from the state before the advance.
module randomizer_lfsr
  import randomizer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic [LFSR_W-1:0] restart_val,
  input  logic              advance,
  output logic              key_bit
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] r_d;
  logic [LFSR_W-1:0] base;

  // A restart replaces the current state before the keystream bit is taken
  always_comb begin
    base    = restart ? restart_val : r_q;
    key_bit = base[0] ^ base[1];
    r_d     = advance ? lfsr_next(base) : r_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= DEFAULT_SEED;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/frame_derandomizer.sv
// Receive-side de-randomizer: per-frame seed reload, bit counting, end-of-frame
// flagging and a single registered output slice with valid/ready on both sides.
module frame_derandomizer
  import randomizer_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_data,
  input  logic              in_sop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic              out_eop,
  output logic              busy,
  output logic              sync_err
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] seed_reg_q, seed_reg_d;
  logic [LFSR_W-1:0] base_seed;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              out_data_q, out_data_d;
  logic              out_eop_q, out_eop_d;
  logic              sync_err_q, sync_err_d;
  logic              accept, restart, advance, key_bit, last_bit;

  // A programmed length of zero stands for 2^LEN_W bits
  function automatic logic [LEN_W:0] eff_len(input logic [LEN_W-1:0] len);
    return {(len == '0), len};
  endfunction

  assign in_ready  = !out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign base_seed = load ? seed : seed_reg_q;
  assign restart   = accept & in_sop;
  assign advance   = accept & (in_sop | (state_q == RUN));

  randomizer_lfsr u_lfsr (
    .clock       (clock),
    .reset       (reset),
    .restart     (restart),
    .restart_val (base_seed),
    .advance     (advance),
    .key_bit     (key_bit)
  );

  always_comb begin
    state_d     = state_q;
    seed_reg_d  = load ? seed : seed_reg_q;
    len_d       = len_q;
    count_d     = count_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_eop_d   = out_eop_q;
    sync_err_d  = 1'b0;
    last_bit    = 1'b0;
    if (accept) begin
      if (in_sop) begin
        sync_err_d = (state_q == RUN);
        len_d      = frame_len;
        count_d    = (LEN_W+1)'(1);
        last_bit   = (count_d == eff_len(frame_len));
      end else if (state_q == RUN) begin
        count_d  = count_q + (LEN_W+1)'(1);
        last_bit = (count_d == eff_len(len_q));
      end else begin
        sync_err_d = 1'b1;
      end
      if (advance) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data ^ key_bit;
        out_eop_d   = last_bit;
        state_d     = last_bit ? IDLE : RUN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_reg_q  <= DEFAULT_SEED;
      len_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_eop_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_reg_q  <= seed_reg_d;
      len_q       <= len_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eop_q   <= out_eop_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eop   = out_eop_q;
  assign sync_err  = sync_err_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_frame_derandomizer.sv
// Directed bench for frame_derandomizer; expected keystreams are worked out by hand
// from the seeds, plus a transmit-side scrambler model for the round-trip frames.
module tb_frame_derandomizer;

  localparam int LEN_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [14:0]      seed = '0;
  logic [LEN_W-1:0] frame_len = 16'd8;
  logic             in_valid = 1'b0;
  logic             in_data = 1'b0;
  logic             in_sop = 1'b0;
  logic             out_ready = 1'b1;
  logic             in_ready, out_valid, out_data, out_eop, busy, sync_err;

  int vectors = 0;
  int miscompares = 0;

  // Keystream bits 0..7 (bit i = i-th bit of a frame) for the seeds used below
  localparam logic [7:0] KS_DEFAULT = 8'hC0;
  localparam logic [7:0] KS_7FFF    = 8'h00;
  localparam logic [7:0] KS_0001    = 8'h01;

  frame_derandomizer #(.LEN_W(LEN_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .seed      (seed),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sop   = s;
  endtask

  // Transmit-side randomizer model used for the round-trip frames
  function automatic logic [15:0] scramble(input logic [14:0] s, input logic [15:0] d);
    logic [14:0] r;
    logic        k;
    logic [15:0] o;
    r = s;
    for (int i = 0; i < 16; i++) begin
      k    = r[0] ^ r[1];
      o[i] = d[i] ^ k;
      r    = {k, r[14:1]};
    end
    return o;
  endfunction

  task automatic test_reset;
    #2;
    vectors++;
    if ({out_valid, out_data, out_eop, busy, sync_err, in_ready} !== 6'b000001) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v/d/e/busy/err/rdy=%b want 000001",
               {out_valid, out_data, out_eop, busy, sync_err, in_ready});
    end
    tick;
    reset = 1'b0;
    tick;
    vectors++;
    if ({out_valid, busy, sync_err} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got v/busy/err=%b want 000", {out_valid, busy, sync_err});
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] exp;
    exp = KS_DEFAULT;
    frame_len = 16'd8;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, i == 0);
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_eop !== (i == 7) || busy !== (i != 7)) begin
        miscompares++;
        $display("[TB] FAIL single_frame bit %0d: got v=%b d=%b e=%b busy=%b want v=1 d=%b e=%b busy=%b",
                 i, out_valid, out_data, out_eop, busy, exp[i], i == 7, i != 7);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_frame_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    d = 8'b1011_0110;
    frame_len = 16'd4;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d[i], (i % 4) == 0);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_ready bit %0d: got in_ready=%b want 1", i, in_ready);
      end
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d[i] || out_eop !== ((i % 4) == 3) || sync_err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL back_to_back bit %0d: got v=%b d=%b e=%b err=%b want v=1 d=%b e=%b err=0",
                 i, out_valid, out_data, out_eop, sync_err, d[i], (i % 4) == 3);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_stall;
    logic [7:0] d, exp;
    d   = 8'b0101_1101;
    exp = d ^ KS_DEFAULT;
    frame_len = 16'd8;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      drive(1'b1, d[k], k == 0);
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_eop !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_pre bit %0d: got v=%b d=%b e=%b want v=1 d=%b e=0",
                 k, out_valid, out_data, out_eop, exp[k]);
      end
    end
    for (int s = 0; s < 3; s++) begin
      out_ready = 1'b0;
      drive(1'b1, d[4], 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_ready cycle %0d: got in_ready=%b want 0", s, in_ready);
      end
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[3] || out_eop !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold cycle %0d: got v=%b d=%b e=%b want v=1 d=%b e=0",
                 s, out_valid, out_data, out_eop, exp[3]);
      end
    end
    for (int k = 4; k < 8; k++) begin
      out_ready = 1'b1;
      drive(1'b1, d[k], 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_resume_ready bit %0d: got in_ready=%b want 1", k, in_ready);
      end
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_eop !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL stall_post bit %0d: got v=%b d=%b e=%b want v=1 d=%b e=%b",
                 k, out_valid, out_data, out_eop, exp[k], k == 7);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_sync_err;
    logic [7:0] kb;
    logic       exp_d;
    int         pulses;
    kb = KS_DEFAULT;
    pulses = 0;
    frame_len = 16'd8;
    // sop on the 4th bit truncates the first frame and restarts
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 1'b0, k == 0 || k == 3);
      tick;
      exp_d = (k >= 3) ? kb[k-3] : 1'b0;
      if (sync_err === 1'b1) pulses++;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_eop !== (k == 10) || sync_err !== (k == 3)) begin
        miscompares++;
        $display("[TB] FAIL resync bit %0d: got v=%b d=%b e=%b err=%b want v=1 d=%b e=%b err=%b",
                 k, out_valid, out_data, out_eop, sync_err, exp_d, k == 10, k == 3);
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL resync_pulse_count: got %0d want 1", pulses);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
    // Bit without sop in IDLE is dropped
    drive(1'b1, 1'b1, 1'b0);
    tick;
    vectors++;
    if (out_valid !== 1'b0 || sync_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_drop: got v=%b err=%b busy=%b want v=0 err=1 busy=0", out_valid, sync_err, busy);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_drop_pulse: got err=%b want 0", sync_err);
    end
    // One-bit frame: eop on the sop bit and no RUN state
    frame_len = 16'd1;
    drive(1'b1, 1'b1, 1'b1);
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 1'b1 || out_eop !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL len_one: got v=%b d=%b e=%b busy=%b want v=1 d=1 e=1 busy=0",
               out_valid, out_data, out_eop, busy);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_load;
    logic [7:0] d, exp;
    logic [7:0] ks [4];
    ks[0] = KS_DEFAULT;
    ks[1] = KS_7FFF;
    ks[2] = KS_0001;
    ks[3] = KS_0001;
    d = 8'hA5;
    frame_len = 16'd8;
    // frame 0: load 7FFF mid-frame; frame 2: load 0001 together with sop
    for (int f = 0; f < 4; f++) begin
      exp = d ^ ks[f];
      for (int k = 0; k < 8; k++) begin
        load = (f == 0 && k == 2) || (f == 2 && k == 0);
        seed = (f == 0) ? 15'h7FFF : 15'h0001;
        drive(1'b1, d[k], k == 0);
        tick;
        load = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp[k] || out_eop !== (k == 7)) begin
          miscompares++;
          $display("[TB] FAIL load frame %0d bit %0d: got v=%b d=%b e=%b want v=1 d=%b e=%b",
                   f, k, out_valid, out_data, out_eop, exp[k], k == 7);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_async_reset;
    logic [7:0] exp;
    exp = KS_DEFAULT;
    load = 1'b1;
    seed = 15'h0001;
    tick;
    load = 1'b0;
    frame_len = 16'd8;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, k == 0);
      tick;
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_data, out_eop, busy, sync_err} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got v/d/e/busy/err=%b want 00000",
               {out_valid, out_data, out_eop, busy, sync_err});
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, k == 0);
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_eop !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL after_reset bit %0d: got v=%b d=%b e=%b want v=1 d=%b e=%b",
                 k, out_valid, out_data, out_eop, exp[k], k == 7);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_round_trip;
    logic [14:0] s;
    logic [15:0] d, tx;
    frame_len = 16'd16;
    for (int f = 0; f < 3; f++) begin
      s  = 15'($urandom);
      d  = 16'($urandom);
      tx = scramble(s, d);
      for (int k = 0; k < 16; k++) begin
        load = (k == 0);
        seed = s;
        drive(1'b1, tx[k], k == 0);
        tick;
        load = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== d[k] || out_eop !== (k == 15)) begin
          miscompares++;
          $display("[TB] FAIL round_trip seed %h bit %0d: got v=%b d=%b e=%b want v=1 d=%b e=%b",
                   s, k, out_valid, out_data, out_eop, d[k], k == 15);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_len_zero;
    int early;
    int last_eop;
    early = 0;
    last_eop = 0;
    frame_len = 16'd0;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 1'b0, i == 0);
      tick;
      if (out_eop === 1'b1) begin
        if (i == 65535) last_eop = 1;
        else early++;
      end
    end
    vectors++;
    if (early != 0 || last_eop != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL len_zero: got early_eops=%0d last_eop=%0d busy=%b want 0 1 0",
               early, last_eop, busy);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_stall;
    test_sync_err;
    test_load;
    test_async_reset;
    test_round_trip;
    test_len_zero;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
